lift_scan_ctrl: RTL and testbench

Parametrised elevator controller that generalises the single-request lift to N floors. Hall and cabin calls are latched into a pending-request vector and served in SCAN order: the car keeps its direction while requests lie ahead and reverses only when none do. Per-floor travel time and door dwell time are counted in clock ticks. The block sits between the button-panel decoders and the floor/door indicators.

---
 rtl/lift_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_lift_scan_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lift_scan_ctrl.sv
// SCAN-order lift controller for N floors: latches hall/cabin calls and keeps
// the car's direction while requests lie ahead, reversing only when none do.
module lift_scan_ctrl #(
  parameter int N_FLOORS    = 8,
  parameter int FLOOR_W     = $clog2(N_FLOORS),
  parameter int FLOOR_TICKS = 4,
  parameter int DOOR_TICKS  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] hall_req_i,
  input  logic [N_FLOORS-1:0] cab_req_i,
  input  logic                door_hold_i,
  output logic [FLOOR_W-1:0]  floor_o,
  output logic                dir_up_o,
  output logic                moving_o,
  output logic                door_open_o,
  output logic                busy_o,
  output logic [N_FLOORS-1:0] pending_o
);

  localparam int MCNT_W = (FLOOR_TICKS > 1) ? $clog2(FLOOR_TICKS) : 1;
  localparam int DCNT_W = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
  localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(FLOOR_TICKS - 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DOOR_TICKS - 1);

  typedef enum logic [1:0] {IDLE, MOVE, DOORS} state_t;

  state_t              state_q, state_d;
  logic [FLOOR_W-1:0]  floor_q, floor_d;
  logic                dir_q, dir_d;
  logic                moving_q, moving_d;
  logic                door_q, door_d;
  logic                busy_q, busy_d;
  logic [N_FLOORS-1:0] pending_q, pending_d;
  logic [MCNT_W-1:0]   mcnt_q, mcnt_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic [N_FLOORS-1:0] clear;
  logic [FLOOR_W-1:0]  floorNext;

  // True when any bit of v lies strictly beyond floor f in the given direction.
  function automatic logic anyBeyond(input logic [N_FLOORS-1:0] v,
                                     input logic [FLOOR_W-1:0] f,
                                     input logic up);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (v[i] && (up ? (i > int'(f)) : (i < int'(f)))) r = 1'b1;
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      floor_q   <= '0;
      dir_q     <= 1'b1;
      moving_q  <= 1'b0;
      door_q    <= 1'b0;
      busy_q    <= 1'b0;
      pending_q <= '0;
      mcnt_q    <= '0;
      dcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      moving_q  <= moving_d;
      door_q    <= door_d;
      busy_q    <= busy_d;
      pending_q <= pending_d;
      mcnt_q    <= mcnt_d;
      dcnt_q    <= dcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_d     = dir_q;
    moving_d  = moving_q;
    door_d    = door_q;
    mcnt_d    = mcnt_q;
    dcnt_d    = dcnt_q;
    clear     = '0;
    floorNext = dir_q ? (floor_q + FLOOR_W'(1)) : (floor_q - FLOOR_W'(1));

    case (state_q)
      IDLE: begin
        if (pending_q[floor_q]) begin
          clear[floor_q] = 1'b1;
          state_d        = DOORS;
          door_d         = 1'b1;
          moving_d       = 1'b0;
          dcnt_d         = '0;
        end else if (anyBeyond(pending_q, floor_q, dir_q)) begin
          state_d  = MOVE;
          moving_d = 1'b1;
          mcnt_d   = '0;
        end else if (anyBeyond(pending_q, floor_q, !dir_q)) begin
          state_d  = MOVE;
          dir_d    = !dir_q;
          moving_d = 1'b1;
          mcnt_d   = '0;
        end
      end

      MOVE: begin
        if (mcnt_q == MCNT_LAST) begin
          // Arrival: the stop/continue decision looks at the floor just reached.
          mcnt_d  = '0;
          floor_d = floorNext;
          if (pending_q[floorNext]) begin
            clear[floorNext] = 1'b1;
            state_d          = DOORS;
            door_d           = 1'b1;
            moving_d         = 1'b0;
            dcnt_d           = '0;
          end else if (!anyBeyond(pending_q, floorNext, dir_q)) begin
            state_d  = IDLE;
            moving_d = 1'b0;
          end
        end else begin
          mcnt_d = mcnt_q + MCNT_W'(1);
        end
      end

      DOORS: begin
        if (door_hold_i || pending_q[floor_q]) begin
          clear[floor_q] = pending_q[floor_q];
          dcnt_d         = '0;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d = IDLE;
          door_d  = 1'b0;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end

      default: begin
        state_d  = IDLE;
        moving_d = 1'b0;
        door_d   = 1'b0;
      end
    endcase

    pending_d = (pending_q | hall_req_i | cab_req_i) & ~clear;
    busy_d    = (state_d != IDLE);
  end

  assign floor_o     = floor_q;
  assign dir_up_o    = dir_q;
  assign moving_o    = moving_q;
  assign door_open_o = door_q;
  assign busy_o      = busy_q;
  assign pending_o   = pending_q;

endmodule

// File: tb/tb_lift_scan_ctrl.sv
// Bench for lift_scan_ctrl: constant vector table, directed SCAN/door/reset
// sequences and random traffic checked against a trip-level reference model.
module tb_lift_scan_ctrl;

  localparam int N  = 8;
  localparam int FW = 3;
  localparam int FT = 4;
  localparam int DT = 3;

  logic          clk;
  logic          rst;
  logic [N-1:0]  hallReq;
  logic [N-1:0]  cabReq;
  logic          doorHold;
  logic [FW-1:0] floor_o;
  logic          dir_up_o;
  logic          moving_o;
  logic          door_open_o;
  logic          busy_o;
  logic [N-1:0]  pending_o;

  int compared   = 0;
  int mismatched = 0;

  lift_scan_ctrl #(
    .N_FLOORS(N), .FLOOR_W(FW), .FLOOR_TICKS(FT), .DOOR_TICKS(DT)
  ) dut (
    .clk(clk), .rst(rst), .hall_req_i(hallReq), .cab_req_i(cabReq),
    .door_hold_i(doorHold), .floor_o(floor_o), .dir_up_o(dir_up_o),
    .moving_o(moving_o), .door_open_o(door_open_o), .busy_o(busy_o),
    .pending_o(pending_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500us;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Trip-level model: phase 0 = parked, 1 = travelling, 2 = doors open.
  // Travel and dwell are tracked as ticks remaining until the next event.
  int           mPhase;
  int           mFloor;
  bit           mUp, mMov, mDoor, mBusy;
  bit [N-1:0]   mPend;
  int           mTravel, mDwell;

  function automatic bit anyBeyond(input bit [N-1:0] p, input int f, input bit up);
    for (int i = 0; i < N; i++)
      if (p[i] && (up ? (i > f) : (i < f))) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelStep(input bit r, input bit [N-1:0] h, input bit [N-1:0] c,
                           input bit hold);
    bit [N-1:0] old;
    bit [N-1:0] served;
    if (r) begin
      mPhase = 0; mFloor = 0; mUp = 1; mMov = 0; mDoor = 0; mBusy = 0;
      mPend = '0; mTravel = 0; mDwell = 0;
      return;
    end
    old    = mPend;
    served = '0;
    case (mPhase)
      0: begin
        if (old[mFloor]) begin
          served[mFloor] = 1; mPhase = 2; mDwell = DT; mDoor = 1;
        end else if (anyBeyond(old, mFloor, mUp)) begin
          mPhase = 1; mTravel = FT; mMov = 1;
        end else if (anyBeyond(old, mFloor, !mUp)) begin
          mUp = !mUp; mPhase = 1; mTravel = FT; mMov = 1;
        end
      end
      1: begin
        mTravel--;
        if (mTravel == 0) begin
          mFloor = mUp ? mFloor + 1 : mFloor - 1;
          if (old[mFloor]) begin
            served[mFloor] = 1; mPhase = 2; mDwell = DT; mDoor = 1; mMov = 0;
          end else if (anyBeyond(old, mFloor, mUp)) begin
            mTravel = FT;
          end else begin
            mPhase = 0; mMov = 0;
          end
        end
      end
      default: begin
        if (hold || old[mFloor]) begin
          served[mFloor] = old[mFloor];
          mDwell = DT;
        end else begin
          mDwell--;
          if (mDwell == 0) begin
            mDoor = 0; mPhase = 0;
          end
        end
      end
    endcase
    mPend = (old | h | c) & ~served;
    mBusy = (mPhase != 0);
  endtask

  function automatic void cmp(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic applyStimulus(input bit r, input bit [N-1:0] h, input bit [N-1:0] c,
                               input bit hold);
    rst = r; hallReq = h; cabReq = c; doorHold = hold;
    @(posedge clk);
    modelStep(r, h, c, hold);
    #1;
  endtask

  task automatic checkOutput();
    cmp("floor",   int'(floor_o),     mFloor);
    cmp("dir_up",  int'(dir_up_o),    int'(mUp));
    cmp("moving",  int'(moving_o),    int'(mMov));
    cmp("door",    int'(door_open_o), int'(mDoor));
    cmp("busy",    int'(busy_o),      int'(mBusy));
    cmp("pending", int'(pending_o),   int'(mPend));
  endtask

  task automatic runUntilIdle(input string tag, input int budget);
    bit done;
    done = 0;
    for (int k = 0; k < budget && !done; k++) begin
      applyStimulus(0, '0, '0, 0);
      checkOutput();
      if (!busy_o && pending_o == '0) done = 1;
    end
    cmp({tag, "_reached_idle"}, int'(done), 1);
  endtask

  typedef struct {
    bit         rst;
    bit [N-1:0] hall;
    bit [N-1:0] cab;
    bit         hold;
    int         fl;
    bit         up, mv, dr, bz;
    bit [N-1:0] pd;
  } vec_t;

  vec_t vecs[$];

  function automatic void push(input bit r, input bit [N-1:0] h, input bit [N-1:0] c,
                               input bit hold, input int fl, input bit up, input bit mv,
                               input bit dr, input bit bz, input bit [N-1:0] pd);
    vec_t v;
    v.rst = r; v.hall = h; v.cab = c; v.hold = hold;
    v.fl = fl; v.up = up; v.mv = mv; v.dr = dr; v.bz = bz; v.pd = pd;
    vecs.push_back(v);
  endfunction

  initial begin
    int  stops[8];
    bit  stopDir[8];
    int  nStops;
    bit  prevDoor, done, moved;
    int  cnt;
    bit [N-1:0] h, c;

    rst = 1; hallReq = '0; cabReq = '0; doorHold = 0;
    mPhase = 0; mFloor = 0; mUp = 1; mMov = 0; mDoor = 0; mBusy = 0;
    mPend = '0; mTravel = 0; mDwell = 0;

    // Reset for two cycles, then a single cabin call to floor 3 from floor 0.
    push(1, '0, '0, 0, 0, 1, 0, 0, 0, '0);
    push(1, '0, '0, 0, 0, 1, 0, 0, 0, '0);
    push(0, '0, 8'h08, 0, 0, 1, 0, 0, 0, 8'h08);
    for (int k = 1; k <= 16; k++)
      push(0, '0, '0, 0,
           (k < 5) ? 0 : (k < 9) ? 1 : (k < 13) ? 2 : 3,
           1, (k <= 12), (k >= 13 && k <= 15), (k <= 15),
           (k <= 12) ? 8'h08 : 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].hall, vecs[i].cab, vecs[i].hold);
      cmp($sformatf("row%0d_floor", i),   int'(floor_o),     vecs[i].fl);
      cmp($sformatf("row%0d_dir", i),     int'(dir_up_o),    int'(vecs[i].up));
      cmp($sformatf("row%0d_moving", i),  int'(moving_o),    int'(vecs[i].mv));
      cmp($sformatf("row%0d_door", i),    int'(door_open_o), int'(vecs[i].dr));
      cmp($sformatf("row%0d_busy", i),    int'(busy_o),      int'(vecs[i].bz));
      cmp($sformatf("row%0d_pending", i), int'(pending_o),   int'(vecs[i].pd));
    end

    // Park at floor 2, then a hall call at the same floor opens without moving.
    applyStimulus(0, '0, 8'h04, 0); checkOutput();
    runUntilIdle("to_floor2", 100);
    applyStimulus(0, 8'h04, '0, 0); checkOutput();
    cnt = 0; moved = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, '0, '0, 0); checkOutput();
      if (door_open_o) cnt++;
      if (moving_o) moved = 1;
    end
    cmp("samefloor_open_cycles", cnt, DT);
    cmp("samefloor_floor", int'(floor_o), 2);
    cmp("samefloor_moved", int'(moved), 0);

    // SCAN: cab 6 from floor 2, then hall 4 and 0 while still at floor 2.
    applyStimulus(0, '0, 8'h40, 0); checkOutput();
    applyStimulus(0, 8'h11, '0, 0); checkOutput();
    cmp("scan_start_floor", int'(floor_o), 2);
    nStops = 0; prevDoor = 0; done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      applyStimulus(0, '0, '0, 0); checkOutput();
      if (door_open_o && !prevDoor && nStops < 8) begin
        stops[nStops] = int'(floor_o);
        stopDir[nStops] = dir_up_o;
        nStops++;
      end
      prevDoor = door_open_o;
      if (!busy_o && pending_o == '0) done = 1;
    end
    cmp("scan_finished", int'(done), 1);
    cmp("scan_stop_count", nStops, 3);
    if (nStops >= 3) begin
      cmp("scan_stop1", stops[0], 4);
      cmp("scan_stop2", stops[1], 6);
      cmp("scan_stop3", stops[2], 0);
      cmp("scan_dir_at_stop3", int'(stopDir[2]), 0);
    end

    // Door hold for 10 cycles at floor 0, then release.
    applyStimulus(0, '0, 8'h01, 0); checkOutput();
    applyStimulus(0, '0, '0, 0); checkOutput();
    cmp("hold_door_opened", int'(door_open_o), 1);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, '0, '0, 1); checkOutput();
      if (door_open_o) cnt++;
    end
    cmp("hold_open_while_held", cnt, 10);
    cnt = 0; done = 0;
    for (int k = 0; k < 10 && !done; k++) begin
      applyStimulus(0, '0, '0, 0); checkOutput();
      cnt++;
      if (!door_open_o) done = 1;
    end
    cmp("hold_close_delay", cnt, DT);

    // Same-floor cab call during dwell restarts the timer: 3 + 3 open cycles.
    applyStimulus(0, '0, 8'h01, 0); checkOutput();
    applyStimulus(0, '0, '0, 0); checkOutput();
    cnt = door_open_o ? 1 : 0;
    applyStimulus(0, '0, '0, 0); checkOutput();
    if (door_open_o) cnt++;
    applyStimulus(0, '0, 8'h01, 0); checkOutput();
    if (door_open_o) cnt++;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      applyStimulus(0, '0, '0, 0); checkOutput();
      if (door_open_o) cnt++; else done = 1;
    end
    cmp("cab_restart_open_cycles", cnt, 6);

    // Reset mid-move at floor 5 with requests 7 and 1 pending.
    applyStimulus(0, '0, 8'h80, 0); checkOutput();
    done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      applyStimulus(0, '0, '0, 0); checkOutput();
      if (floor_o == 3'd5) done = 1;
    end
    cmp("reach_floor5", int'(done), 1);
    applyStimulus(0, 8'h02, '0, 0); checkOutput();
    cmp("pre_reset_moving", int'(moving_o), 1);
    cmp("pre_reset_pending", int'(pending_o), 8'h82);
    applyStimulus(1, '0, '0, 0); checkOutput();
    cmp("rst_floor", int'(floor_o), 0);
    cmp("rst_pending", int'(pending_o), 0);
    cmp("rst_moving", int'(moving_o), 0);
    cmp("rst_busy", int'(busy_o), 0);
    cmp("rst_dir", int'(dir_up_o), 1);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      h = '0; c = '0;
      if ($urandom_range(0, 7) == 0) h[$urandom_range(0, N-1)] = 1'b1;
      if ($urandom_range(0, 7) == 0) c[$urandom_range(0, N-1)] = 1'b1;
      applyStimulus(($urandom_range(0, 399) == 0), h, c, ($urandom_range(0, 15) == 0));
      checkOutput();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
